lcd_byte_writer: RTL and testbench

- Downstream consumer of the MiniAlu LCD instruction. It captures each byte strobed out by the ALU (8-bit data plus a write pulse) into a small FIFO.
- On its own, it runs the HD44780 4-bit power-on initialisation and configuration sequence.
- Once initialised, it serialises every queued byte onto the character-LCD pins as two timed nibbles.
- The ALU never stalls. Bytes arriving while the LCD is slow are buffered, and bytes arriving when the buffer is full are dropped and flagged.

---
 rtl/lcd_byte_writer_if.sv | 18 +
 rtl/lcd_byte_writer.sv | 247 ++++++++++++++++++++++++
 tb/tb_lcd_byte_writer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_byte_writer_if.sv
// Write-side bus between the MiniAlu LCD instruction and lcd_byte_writer.
// master: byte producer (iData, iRS, iWrite) observing the status flags.
// slave : lcd_byte_writer, which accepts bytes and reports oFull, oOverflow,
//         oBusy and oInitDone.
interface lcd_byte_writer_if;
   logic [7:0] iData;
   logic       iRS;
   logic       iWrite;
   logic       oFull;
   logic       oOverflow;
   logic       oBusy;
   logic       oInitDone;

   modport master (output iData, iRS, iWrite,
                   input  oFull, oOverflow, oBusy, oInitDone);
   modport slave  (input  iData, iRS, iWrite,
                   output oFull, oOverflow, oBusy, oInitDone);
endinterface

// File: rtl/lcd_byte_writer.sv
// HD44780 4-bit byte writer. Buffers {RS, data} bytes strobed by the ALU in a
// FIFO, runs the power-on init/config sequence, then sends each queued byte
// as two timed nibbles on the LCD pins.
// Ports: Clock, Reset (sync, active high); bus (slave: iData, iRS, iWrite in;
//        oFull, oOverflow, oBusy, oInitDone out); oLCD_E, oLCD_RS, oLCD_RW,
//        oLCD_Data[3:0] (DB7..DB4) to the panel.
module lcd_byte_writer #(
   parameter int unsigned FIFO_AW   = 4,
   parameter int unsigned T_POWERUP = 750000,
   parameter int unsigned T_INIT1   = 205000,
   parameter int unsigned T_INIT2   = 5000,
   parameter int unsigned T_CMD     = 2000,
   parameter int unsigned T_CLEAR   = 82000,
   parameter int unsigned T_NIBBLE  = 50,
   parameter int unsigned T_SETUP   = 2,
   parameter int unsigned T_EPULSE  = 12,
   parameter int unsigned T_HOLD    = 1
) (
   input  logic             Clock,
   input  logic             Reset,
   lcd_byte_writer_if.slave bus,
   output logic             oLCD_E,
   output logic             oLCD_RS,
   output logic             oLCD_RW,
   output logic [3:0]       oLCD_Data
);

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned PW    = FIFO_AW + 1;
   localparam int unsigned T_MAX = max2(max2(max2(T_POWERUP, T_INIT1), max2(T_INIT2, T_CMD)),
                                        max2(max2(T_CLEAR, T_NIBBLE),
                                             max2(max2(T_SETUP, T_EPULSE), T_HOLD)));
   localparam int unsigned CW    = $clog2(T_MAX + 1);

   typedef enum logic [3:0] {
      POWERUP_WAIT, SETUP_HI, E_HI, HOLD_HI, GAP,
      SETUP_LO, E_LO, HOLD_LO, WAIT, IDLE
   } stateT;

   // Counter load value for a state lasting t cycles
   function automatic logic [CW-1:0] ld(input int unsigned t);
      return CW'(t - 32'd1);
   endfunction

   function automatic int unsigned waitFor(input logic rs, input logic [7:0] b);
      return (!rs && (b == 8'h01 || b == 8'h02)) ? T_CLEAR : T_CMD;
   endfunction

   // Init steps 0..3 are high-nibble-only, 4..7 are full config bytes
   function automatic logic [7:0] initByte(input logic [2:0] s);
      case (s)
         3'd0, 3'd1, 3'd2: return 8'h30;
         3'd3:             return 8'h20;
         3'd4:             return 8'h28;
         3'd5:             return 8'h06;
         3'd6:             return 8'h0C;
         default:          return 8'h01;
      endcase
   endfunction

   function automatic logic [CW-1:0] initWaitLd(input logic [2:0] s);
      if (s[2]) return ld(waitFor(1'b0, initByte(s)));
      case (s[1:0])
         2'd0:    return ld(T_INIT1);
         2'd1:    return ld(T_INIT2);
         default: return ld(T_CMD);
      endcase
   endfunction

   stateT         state, stateNext;
   logic [CW-1:0] count, countNext;
   logic [2:0]    initStep, initStepNext;
   logic [3:0]    curLo, curLoNext;
   logic          curNib, curNibNext;
   logic [CW-1:0] curWait, curWaitNext;
   logic [PW-1:0] rdPtr, rdPtrNext, wrPtr, wrPtrNext;
   logic          fullQ, fullNext, ovfQ, ovfNext, busyQ, busyNext, doneQ, doneNext;
   logic          lcdE, lcdENext, lcdRS, lcdRSNext;
   logic [3:0]    lcdData, lcdDataNext;
   logic          push, pop, start, ldRS, ldNib, emptyNext;
   logic [7:0]    ldByte;
   logic [CW-1:0] ldWait;
   logic [8:0]    mem [DEPTH];
   logic [8:0]    memRd;
   logic          empty, expired;

   assign empty   = (wrPtr == rdPtr);
   assign expired = (count == '0);
   assign memRd   = mem[rdPtr[FIFO_AW-1:0]];

   // FIFO storage; flushing is done by resetting the pointers
   always_ff @(posedge Clock) begin
      if (push) mem[wrPtr[FIFO_AW-1:0]] <= {bus.iRS, bus.iData};
   end

   // Next state, counter, FIFO pointers and registered outputs
   always_comb begin
      stateNext    = state;
      countNext    = expired ? count : count - CW'(1);
      initStepNext = initStep;
      curLoNext    = curLo;
      curNibNext   = curNib;
      curWaitNext  = curWait;
      doneNext     = doneQ;
      lcdRSNext    = lcdRS;
      lcdDataNext  = lcdData;
      pop          = 1'b0;
      start        = 1'b0;
      ldByte       = 8'h00;
      ldRS         = 1'b0;
      ldNib        = 1'b0;
      ldWait       = '0;

      case (state)
         POWERUP_WAIT: if (expired) begin
            start  = 1'b1;
            ldByte = initByte(3'd0);
            ldNib  = 1'b1;
            ldWait = initWaitLd(3'd0);
         end
         SETUP_HI: if (expired) begin
            stateNext = E_HI;
            countNext = ld(T_EPULSE);
         end
         E_HI: if (expired) begin
            stateNext = HOLD_HI;
            countNext = ld(T_HOLD);
         end
         HOLD_HI: if (expired) begin
            stateNext = curNib ? WAIT : GAP;
            countNext = curNib ? curWait : ld(T_NIBBLE);
         end
         GAP: if (expired) begin
            stateNext   = SETUP_LO;
            countNext   = ld(T_SETUP);
            lcdDataNext = curLo;
         end
         SETUP_LO: if (expired) begin
            stateNext = E_LO;
            countNext = ld(T_EPULSE);
         end
         E_LO: if (expired) begin
            stateNext = HOLD_LO;
            countNext = ld(T_HOLD);
         end
         HOLD_LO: if (expired) begin
            stateNext = WAIT;
            countNext = curWait;
         end
         WAIT: if (expired) begin
            if (doneQ) begin
               stateNext = IDLE;
            end else if (initStep == 3'd7) begin
               stateNext = IDLE;
               doneNext  = 1'b1;
            end else begin
               initStepNext = initStep + 3'd1;
               start        = 1'b1;
               ldByte       = initByte(initStepNext);
               ldNib        = ~initStepNext[2];
               ldWait       = initWaitLd(initStepNext);
            end
         end
         IDLE: if (doneQ && !empty) begin
            pop    = 1'b1;
            start  = 1'b1;
            ldByte = memRd[7:0];
            ldRS   = memRd[8];
            ldWait = ld(waitFor(memRd[8], memRd[7:0]));
         end
         default: stateNext = POWERUP_WAIT;
      endcase

      // Common entry into a transfer: RS and the high nibble go out with SETUP_HI
      if (start) begin
         stateNext   = SETUP_HI;
         countNext   = ld(T_SETUP);
         curLoNext   = ldByte[3:0];
         curNibNext  = ldNib;
         curWaitNext = ldWait;
         lcdRSNext   = ldRS;
         lcdDataNext = ldByte[7:4];
      end

      // A full FIFO drops the write even when the same edge pops
      push      = bus.iWrite && !fullQ;
      wrPtrNext = wrPtr + PW'(push);
      rdPtrNext = rdPtr + PW'(pop);
      emptyNext = (wrPtrNext == rdPtrNext);
      fullNext  = (wrPtrNext[FIFO_AW] != rdPtrNext[FIFO_AW]) &&
                  (wrPtrNext[FIFO_AW-1:0] == rdPtrNext[FIFO_AW-1:0]);
      ovfNext   = ovfQ | (bus.iWrite & fullQ);
      busyNext  = !((stateNext == IDLE) && doneNext && emptyNext);
      lcdENext  = (stateNext == E_HI) || (stateNext == E_LO);
   end

   // State and datapath registers
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= POWERUP_WAIT;
         count    <= ld(T_POWERUP);
         initStep <= 3'd0;
         curLo    <= 4'h0;
         curNib   <= 1'b0;
         curWait  <= '0;
         rdPtr    <= '0;
         wrPtr    <= '0;
         fullQ    <= 1'b0;
         ovfQ     <= 1'b0;
         busyQ    <= 1'b1;
         doneQ    <= 1'b0;
         lcdE     <= 1'b0;
         lcdRS    <= 1'b0;
         lcdData  <= 4'h0;
      end else begin
         state    <= stateNext;
         count    <= countNext;
         initStep <= initStepNext;
         curLo    <= curLoNext;
         curNib   <= curNibNext;
         curWait  <= curWaitNext;
         rdPtr    <= rdPtrNext;
         wrPtr    <= wrPtrNext;
         fullQ    <= fullNext;
         ovfQ     <= ovfNext;
         busyQ    <= busyNext;
         doneQ    <= doneNext;
         lcdE     <= lcdENext;
         lcdRS    <= lcdRSNext;
         lcdData  <= lcdDataNext;
      end
   end

   assign bus.oFull      = fullQ;
   assign bus.oOverflow  = ovfQ;
   assign bus.oBusy      = busyQ;
   assign bus.oInitDone  = doneQ;
   assign oLCD_E         = lcdE;
   assign oLCD_RS        = lcdRS;
   assign oLCD_RW        = 1'b0;
   assign oLCD_Data      = lcdData;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Self-checking bench for lcd_byte_writer: expected nibbles and E-rise
// spacing are queued by the stimulus from a transaction-level model; a
// monitor pops and compares on every E rising edge.
module tb_lcd_byte_writer;

   localparam int T_POWERUP = 100;
   localparam int T_INIT1   = 50;
   localparam int T_INIT2   = 20;
   localparam int T_CMD     = 10;
   localparam int T_CLEAR   = 30;
   localparam int T_NIBBLE  = 4;
   localparam int T_SETUP   = 2;
   localparam int T_EPULSE  = 3;
   localparam int T_HOLD    = 1;
   localparam int NIB_GAP   = T_EPULSE + T_HOLD + T_NIBBLE + T_SETUP;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       lcdE, lcdRS, lcdRW;
   logic [3:0] lcdData;

   lcd_byte_writer_if bus();

   lcd_byte_writer #(
      .FIFO_AW(4), .T_POWERUP(T_POWERUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2),
      .T_CMD(T_CMD), .T_CLEAR(T_CLEAR), .T_NIBBLE(T_NIBBLE), .T_SETUP(T_SETUP),
      .T_EPULSE(T_EPULSE), .T_HOLD(T_HOLD)
   ) dut (
      .Clock(Clock), .Reset(Reset), .bus(bus),
      .oLCD_E(lcdE), .oLCD_RS(lcdRS), .oLCD_RW(lcdRW), .oLCD_Data(lcdData)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic       rs;
      logic [3:0] nib;
      int         gap;        // cycles since previous E rise (or reset edge); -1 = unchecked
      bit         fromReset;
   } expT;

   expT sb[$];
   int  total = 0, bad = 0;
   int  cyc = 0, anchor = 0, lastRise = 0;
   int  prevWaitModel = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int waitFor(input logic rs, input logic [7:0] b);
      return (!rs && (b == 8'h01 || b == 8'h02)) ? T_CLEAR : T_CMD;
   endfunction

   function automatic int byteCost(input int w);
      return 2 * (T_SETUP + T_EPULSE + T_HOLD) + T_NIBBLE + w;
   endfunction

   // Expected init traffic: four bare nibbles, then four config bytes
   task automatic pushInit(output int initLen);
      logic [7:0] ib [8];
      int         iw [4];
      int         gap;
      ib = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h28, 8'h06, 8'h0C, 8'h01};
      iw = '{T_INIT1, T_INIT2, T_CMD, T_CMD};
      initLen = T_POWERUP;
      for (int i = 0; i < 8; i++) begin
         gap = (i == 0) ? T_POWERUP + T_SETUP : T_EPULSE + T_HOLD + prevWaitModel + T_SETUP;
         sb.push_back('{1'b0, ib[i][7:4], gap, i == 0});
         if (i < 4) begin
            prevWaitModel = iw[i];
            initLen += T_SETUP + T_EPULSE + T_HOLD + iw[i];
         end else begin
            sb.push_back('{1'b0, ib[i][3:0], NIB_GAP, 1'b0});
            prevWaitModel = waitFor(1'b0, ib[i]);
            initLen += byteCost(prevWaitModel);
         end
      end
   endtask

   // A chained byte was already queued when the previous one finished its wait
   task automatic pushUser(input logic rs, input logic [7:0] b, input bit chained);
      int hiGap;
      hiGap = chained ? T_EPULSE + T_HOLD + prevWaitModel + 1 + T_SETUP : -1;
      sb.push_back('{rs, b[7:4], hiGap, 1'b0});
      sb.push_back('{rs, b[3:0], NIB_GAP, 1'b0});
      prevWaitModel = waitFor(rs, b);
   endtask

   function automatic bit cond(input int w);
      case (w)
         0:       return !bus.oBusy;
         1:       return bus.oInitDone;
         2:       return lcdE;
         default: return !bus.oFull;
      endcase
   endfunction

   task automatic waitUntil(input int w, input int maxc, input string nm);
      int n;
      n = 0;
      while (!cond(w) && n < maxc) begin
         @(negedge Clock);
         n++;
      end
      if (!cond(w)) begin
         total++;
         bad++;
         $display("FAIL %s: waited %0d cycles, limit %0d", nm, n, maxc);
      end
   endtask

   task automatic drive(input logic rs, input logic [7:0] b);
      bus.iWrite = 1'b1;
      bus.iRS    = rs;
      bus.iData  = b;
      @(negedge Clock);
   endtask

   // Monitor: one sample per cycle, 1 time unit after the rising edge
   initial begin
      logic       prevE, rsAtRise;
      logic [3:0] dAtRise;
      int         width;
      bit         inPulse;
      expT        e;
      prevE = 1'b0; rsAtRise = 1'b0; dAtRise = 4'h0; width = 0; inPulse = 1'b0;
      forever begin
         @(posedge Clock);
         #1;
         cyc++;
         if (Reset) begin
            anchor  = cyc;
            inPulse = 1'b0;
            prevE   = lcdE;
         end else begin
            if (lcdE && !prevE) begin
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpectedPulse: got RS=%0d D=%h, expected no pulse", lcdRS, lcdData);
               end else begin
                  e = sb.pop_front();
                  check("pulseRS", int'(lcdRS), int'(e.rs));
                  check("pulseData", int'(lcdData), int'(e.nib));
                  check("pulseRW", int'(lcdRW), 0);
                  if (e.fromReset)       check("riseFromReset", cyc - anchor, e.gap);
                  else if (e.gap >= 0)   check("riseGap", cyc - lastRise, e.gap);
               end
               lastRise = cyc;
               inPulse  = 1'b1;
               width    = 1;
               rsAtRise = lcdRS;
               dAtRise  = lcdData;
            end else if (lcdE && prevE) begin
               width++;
            end else if (!lcdE && prevE && inPulse) begin
               check("pulseWidth", width, T_EPULSE);
               check("holdRS", int'(lcdRS), int'(rsAtRise));
               check("holdData", int'(lcdData), int'(dAtRise));
               inPulse = 1'b0;
            end
            prevE = lcdE;
         end
      end
   end

   // Stimulus
   initial begin
      int         initLen, wEdge, n;
      logic [7:0] b;
      logic       rs;
      bus.iWrite = 1'b0;
      bus.iRS    = 1'b0;
      bus.iData  = 8'h00;

      // Reset state and init sequence with no writes
      pushInit(initLen);
      repeat (3) @(negedge Clock);
      check("rstE", int'(lcdE), 0);
      check("rstRS", int'(lcdRS), 0);
      check("rstData", int'(lcdData), 0);
      check("rstRW", int'(lcdRW), 0);
      check("rstInitDone", int'(bus.oInitDone), 0);
      check("rstOverflow", int'(bus.oOverflow), 0);
      check("rstFull", int'(bus.oFull), 0);
      check("rstBusy", int'(bus.oBusy), 1);
      Reset = 1'b0;
      waitUntil(1, 2000, "initDone");
      check("initDoneTime", cyc - anchor, initLen);
      check("busyAtInitDone", int'(bus.oBusy), 0);
      check("initQueueDrained", sb.size(), 0);

      // Single character into an idle engine: latency and busy duration
      pushUser(1'b1, 8'h41, 1'b0);
      wEdge = cyc + 1;
      drive(1'b1, 8'h41);
      bus.iWrite = 1'b0;
      waitUntil(2, 50, "firstE41");
      check("writeToE", cyc - wEdge, T_SETUP + 1);
      waitUntil(0, 200, "idle41");
      check("busyDuration", cyc - wEdge, 1 + byteCost(T_CMD));

      // Clear command followed by queued bytes: long then normal waits
      pushUser(1'b0, 8'h01, 1'b0); drive(1'b0, 8'h01);
      pushUser(1'b1, 8'h42, 1'b1); drive(1'b1, 8'h42);
      pushUser(1'b0, 8'h80, 1'b1); drive(1'b0, 8'h80);
      bus.iWrite = 1'b0;
      waitUntil(0, 500, "idleClear");

      // Random batches, short gaps between writes
      for (int batch = 0; batch < 4; batch++) begin
         n = $urandom_range(1, 10);
         for (int i = 0; i < n; i++) begin
            rs = 1'($urandom_range(0, 1));
            b  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom);
            pushUser(rs, b, i > 0);
            drive(rs, b);
            bus.iWrite = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge Clock);
         end
         waitUntil(0, 2000, "idleRandom");
         check("randomQueueDrained", sb.size(), 0);
      end

      // Fill the FIFO behind a byte in flight, keep writing until the pop frees a slot
      pushUser(1'b1, 8'h55, 1'b0);
      drive(1'b1, 8'h55);
      for (int i = 0; i < 16; i++) begin
         b = 8'($urandom);
         pushUser(1'b1, b, 1'b1);
         drive(1'b1, b);
      end
      bus.iWrite = 1'b0;
      check("fullAfter16", int'(bus.oFull), 1);
      n = 0;
      while (bus.oFull && n < 200) begin
         drive(1'b1, 8'hEE);
         n++;
      end
      bus.iWrite = 1'b0;
      check("fullReleased", int'(bus.oFull), 0);
      check("overflowOnPopEdge", int'(bus.oOverflow), 1);
      waitUntil(0, 2000, "idleFull");
      check("fullQueueDrained", sb.size(), 0);

      // Reset during E high of a byte with more bytes queued
      for (int i = 0; i < 4; i++) begin
         pushUser(1'b1, 8'(8'h61 + i), i > 0);
         drive(1'b1, 8'(8'h61 + i));
      end
      bus.iWrite = 1'b0;
      waitUntil(2, 50, "eBeforeReset");
      Reset = 1'b1;
      sb.delete();
      pushInit(initLen);
      @(negedge Clock);
      check("midResetE", int'(lcdE), 0);
      check("midResetInitDone", int'(bus.oInitDone), 0);
      check("midResetOverflow", int'(bus.oOverflow), 0);
      check("midResetFull", int'(bus.oFull), 0);
      check("midResetBusy", int'(bus.oBusy), 1);
      Reset = 1'b0;

      // 17 writes during init: 16 queued, the last dropped
      repeat (5) @(negedge Clock);
      for (int i = 0; i < 17; i++) begin
         b = 8'(8'h30 + i);
         if (i < 16) pushUser(1'b1, b, 1'b1);
         drive(1'b1, b);
         if (i == 14) check("notFullAfter15", int'(bus.oFull), 0);
         if (i == 15) check("fullAfter16Init", int'(bus.oFull), 1);
         if (i == 15) check("noOverflowYet", int'(bus.oOverflow), 0);
      end
      bus.iWrite = 1'b0;
      check("overflowAfter17", int'(bus.oOverflow), 1);
      waitUntil(1, 2000, "initDone2");
      check("initDoneTime2", cyc - anchor, initLen);
      waitUntil(0, 3000, "idleBurst");
      repeat (5) @(negedge Clock);
      check("finalQueueDrained", sb.size(), 0);
      check("finalIdle", int'(bus.oBusy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
